// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: time-slots NUM_DIGITS digits with an
// anode-off guard, frame-aligned double buffering and leading-zero blanking.

// Active-low hex-to-segment decoder for one digit; blank forces all segments off.
module seg7_digit_dec (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      unique case (nib)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        default: seg = 7'b0001110;
      endcase
    end
  end
endmodule

module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 8333,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en7Seg,
  input  logic [4*NUM_DIGITS-1:0] hex,
  input  logic [NUM_DIGITS-1:0]   dpIn,
  input  logic                    lzBlank,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [6:0]              segs,
  output logic                    decimalPt,
  output logic                    frameDone
);
  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          slot_end, frame_end, guard;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= frame_end ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  generate
    if (GUARD_CYCLES == 0) begin : g_noguard
      assign guard = 1'b0;
    end else begin : g_guard
      assign guard = ({{(32-CW){1'b0}}, cnt} < 32'(GUARD_CYCLES));
    end
  endgenerate

  // Double buffer: loads land in pend and only reach disp at the frame boundary,
  // so a frame never mixes two loads.
  logic [4*NUM_DIGITS-1:0] pend_hex, disp_hex;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
  logic                    pend_lz, disp_lz, pend_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_hex <= '0;
      pend_dp  <= '0;
      pend_lz  <= 1'b0;
      pend_vld <= 1'b0;
      disp_hex <= '0;
      disp_dp  <= '0;
      disp_lz  <= 1'b0;
    end else begin
      if (load) begin
        pend_hex <= hex;
        pend_dp  <= dpIn;
        pend_lz  <= lzBlank;
      end
      if (frame_end) begin
        pend_vld <= 1'b0;
        if (load) begin
          disp_hex <= hex;
          disp_dp  <= dpIn;
          disp_lz  <= lzBlank;
        end else if (pend_vld) begin
          disp_hex <= pend_hex;
          disp_dp  <= pend_dp;
          disp_lz  <= pend_lz;
        end
      end else if (load) begin
        pend_vld <= 1'b1;
      end
    end
  end

  // hi_zero[i]: digit i and every digit above it are zero.
  logic [NUM_DIGITS:0]            hi_zero;
  logic [NUM_DIGITS-1:0]          blank;
  logic [NUM_DIGITS-1:0][6:0]     dec;

  assign hi_zero[NUM_DIGITS] = 1'b1;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      assign hi_zero[i] = hi_zero[i+1] && (disp_hex[4*i +: 4] == 4'h0);
      if (i == 0) begin : g_first
        assign blank[i] = 1'b0;
      end else begin : g_rest
        assign blank[i] = disp_lz && hi_zero[i];
      end
      seg7_digit_dec u_dec (
        .nib   (disp_hex[4*i +: 4]),
        .blank (blank[i]),
        .seg   (dec[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anodes    <= '1;
      segs      <= 7'b1111111;
      decimalPt <= 1'b1;
      frameDone <= 1'b0;
    end else begin
      anodes    <= (en7Seg && !guard) ? ~(NUM_DIGITS'(1) << idx) : '1;
      segs      <= dec[idx];
      decimalPt <= ~disp_dp[idx];
      frameDone <= frame_end;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: stimulus pushes expected pin values computed from frame
// arithmetic; a negedge monitor pops and compares every cycle.
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int S = 4;
  localparam int G = 1;
  localparam int FR = N * S;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en7Seg = 1'b0;
  logic [15:0]   hex = '0;
  logic [3:0]    dpIn = '0;
  logic          lzBlank = 1'b0;
  logic          load = 1'b0;
  logic [3:0]    anodes;
  logic [6:0]    segs;
  logic          decimalPt;
  logic          frameDone;

  seg7_scan_driver #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .en7Seg(en7Seg), .hex(hex), .dpIn(dpIn),
    .lzBlank(lzBlank), .load(load), .anodes(anodes), .segs(segs),
    .decimalPt(decimalPt), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
    logic       fd;
  } pins_t;

  localparam pins_t RST_PINS = '{an: 4'hF, sg: 7'h7F, dp: 1'b1, fd: 1'b0};

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  pins_t expq[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state: t counts cycles since reset release.
  int          t;
  pins_t       cur;
  logic [15:0] d_hex, p_hex;
  logic [3:0]  d_dp, p_dp;
  logic        d_lz, p_lz, p_flag;
  logic        cur_en = 1'b1;

  function automatic pins_t model_pins(input int tt, input logic en);
    pins_t p;
    int cnt = tt % S;
    int ix  = (tt / S) % N;
    logic [15:0] upper = d_hex >> (4 * ix);
    p.an = (en && cnt >= G) ? ~(4'b0001 << ix) : 4'hF;
    p.sg = (d_lz && ix > 0 && upper == 16'h0) ? 7'h7F : seg_tab[upper[3:0]];
    p.dp = ~d_dp[ix];
    p.fd = (tt % FR) == FR - 1;
    return p;
  endfunction

  task automatic step(input bit ld, input logic [15:0] hx, input logic [3:0] dv, input bit lz);
    expq.push_back(cur);
    load = ld; hex = hx; dpIn = dv; lzBlank = lz; en7Seg = cur_en;
    cur = model_pins(t, cur_en);
    if ((t % FR) == FR - 1) begin
      if (ld) begin d_hex = hx; d_dp = dv; d_lz = lz; end
      else if (p_flag) begin d_hex = p_hex; d_dp = p_dp; d_lz = p_lz; end
      p_flag = 1'b0;
    end else if (ld) begin
      p_hex = hx; p_dp = dv; p_lz = lz; p_flag = 1'b1;
    end
    t++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, $urandom);
  endtask

  task automatic run_to(input int phase);
    int guard_cnt = 0;
    while ((t % FR) != phase && guard_cnt < FR) begin
      step(1'b0, '0, '0, 1'b0);
      guard_cnt++;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; load = 1'b0;
    cur = RST_PINS; t = 0;
    d_hex = '0; d_dp = '0; d_lz = 1'b0;
    p_hex = '0; p_dp = '0; p_lz = 1'b0; p_flag = 1'b0;
    for (int i = 0; i < n; i++) begin
      expq.push_back(RST_PINS);
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      pins_t e, a;
      e = expq.pop_front();
      a = '{an: anodes, sg: segs, dp: decimalPt, fd: frameDone};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL pins @%0t: got an=%b sg=%b dp=%b fd=%b, want an=%b sg=%b dp=%b fd=%b",
                 $time, a.an, a.sg, a.dp, a.fd, e.an, e.sg, e.dp, e.fd);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    do_reset(3);
    // load on first cycle after release, then show 0x1234
    step(1'b1, 16'h1234, 4'b0000, 1'b0);
    idle(2 * FR);
    // leading-zero blanking with a dp on a blanked digit
    step(1'b1, 16'h0005, 4'b0100, 1'b1);
    idle(2 * FR + 3);
    step(1'b1, 16'h0000, 4'b0000, 1'b1);
    idle(2 * FR);
    // mid-frame reload and overwrite of pending value
    step(1'b1, 16'hAAAA, 4'b1111, 1'b0);
    run_to(6);
    step(1'b1, 16'h1111, 4'b0001, 1'b0);
    step(1'b1, 16'hBBBB, 4'b0000, 1'b0);
    idle(2 * FR);
    // load exactly on the frame-wrap cycle
    run_to(FR - 1);
    step(1'b1, 16'hC0DE, 4'b1010, 1'b0);
    idle(2 * FR);
    // display disabled for two frames, re-enabled mid-frame
    run_to(5);
    cur_en = 1'b0;
    idle(2 * FR);
    cur_en = 1'b1;
    idle(FR + 4);
    // reset asserted in digit-2 slot at count 2
    step(1'b1, 16'h9876, 4'b0011, 1'b0);
    idle(FR);
    run_to(2 * S + 2);
    do_reset(2);
    idle(FR + 2);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) cur_en = ~cur_en;
      step($urandom_range(0, 11) == 0, $urandom, $urandom, $urandom_range(0, 1) == 1);
    end
    cur_en = 1'b1;
    idle(4);
    @(negedge clk); #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface

Parameters:
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed digits, legal range 2..8.
REQ-002 The block SHALL have parameter SLOT_CYCLES, default 8333, giving the clk cycles per digit slot, legal range 4..2^24.
REQ-003 The block SHALL have parameter GUARD_CYCLES, default 2, giving the all-anodes-off cycles at the start of each slot, legal range 0..SLOT_CYCLES-2.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port en7Seg, input, 1 bit: display enable, active high.
REQ-007 The block SHALL have port hex, input, 4*NUM_DIGITS bits: digit i is hex[4i+3:4i], and digit 0 is rightmost.
REQ-008 The block SHALL have port dpIn, input, NUM_DIGITS bits: per-digit decimal point request, active high.
REQ-009 The block SHALL have port lzBlank, input, 1 bit: leading-zero suppression enable.
REQ-010 The block SHALL have port load, input, 1 bit: a single-cycle strobe that captures hex, dpIn and lzBlank.
REQ-011 The block SHALL have port anodes, output, NUM_DIGITS bits: digit enables, active low, registered.
REQ-012 The block SHALL have port segs, output, 7 bits: cathodes, active low, with segs[6:0] = {G,F,E,D,C,B,A}, registered.
REQ-013 The block SHALL have port decimalPt, output, 1 bit: the decimal point cathode, active low, registered.
REQ-014 The block SHALL have port frameDone, output, 1 bit: a one-cycle pulse when the last digit slot ends.

Function

REQ-015 The slot counter SHALL count 0..SLOT_CYCLES-1 and wrap to 0; at wrap, the digit index SHALL advance by 1 modulo NUM_DIGITS.
REQ-016 A frame SHALL be defined as NUM_DIGITS consecutive slots, beginning when the digit index becomes 0.
REQ-017 During slot counts 0..GUARD_CYCLES-1, anodes SHALL be all 1; for the remaining counts of the slot, only anodes[index] SHALL be 0.
REQ-018 When en7Seg is 0, anodes SHALL be all 1, while the counters and index keep running.
REQ-019 Outputs SHALL be registered, with one cycle of latency from counter and index state to the pins.
REQ-020 The load strobe SHALL write hex, dpIn and lzBlank into a pending register and set a pending flag.
REQ-021 At the cycle where the index wraps from NUM_DIGITS-1 to 0, if the pending flag is set, the pending contents SHALL be copied to the display register and the flag cleared.
REQ-022 If load coincides with that wrap cycle, the live inputs SHALL go directly to the display register and the flag SHALL end clear.
REQ-023 A second load before the next frame boundary SHALL overwrite the pending values, so only the last load is displayed.
REQ-024 A displayed frame SHALL never mix old and new values.
REQ-025 Segment encoding SHALL be standard hex, active low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-026 With lzBlank latched at 1, any digit i>0 whose value, and all higher digits' values, are 0 SHALL show segs=1111111.
REQ-027 Digit 0 SHALL never be suppressed by leading-zero blanking.
REQ-028 A suppressed digit with its dp bit set SHALL still drive decimalPt=0.
REQ-029 decimalPt SHALL equal the inverse of the latched dp bit of the current digit.
REQ-030 frameDone SHALL pulse for 1 cycle, registered, on the cycle after the last slot of digit NUM_DIGITS-1 ends.
REQ-031 frameDone SHALL pulse regardless of en7Seg.

Reset

REQ-032 While rst=1, the slot counter SHALL be 0 and the index SHALL be 0.
REQ-033 While rst=1, anodes SHALL be all 1, segs=1111111, decimalPt=1 and frameDone=0.
REQ-034 While rst=1, the display and pending registers SHALL be 0 and the pending flag clear.
REQ-035 Reset asserted mid-slot or mid-frame SHALL abort immediately; after release, scanning SHALL restart at digit 0, count 0.
REQ-036 A load on the first cycle after reset release SHALL be honoured.

Verification

All scenarios use NUM_DIGITS=4, SLOT_CYCLES=4, GUARD_CYCLES=1.

REQ-037 Scenario: release reset, en7Seg=1, load hex=0x1234 with dp=0 and lzBlank=0 -> after the next frame boundary, slots show anodes 1110/segs 0011001 (digit 4), 1101/0110000, 1011/0100100, 0111/1111001, and each slot's first cycle has anodes=1111.
REQ-038 Scenario: load 0x0005 with lzBlank=1 and dpIn=0100 -> digits 3 and 1 are blank; digit 2 is blank with decimalPt=0; digit 0 shows 0010010; the value 0x0000 shows only digit 0 as 1000000.
REQ-039 Scenario: load 0xAAAA, then load 0xBBBB mid-frame -> the current frame stays entirely 0xAAAA (or the prior value) and the next frame is entirely 0xBBBB with no mixing.
REQ-040 Scenario: load asserted exactly on the index-wrap cycle -> the new value appears in the frame starting that cycle, and the pending flag is clear afterwards.
REQ-041 Scenario: en7Seg=0 for 2 frames -> anodes=1111 throughout and frameDone pulses every 16 cycles; on re-enable the scan continues at the current index, not 0.
REQ-042 Scenario: rst pulsed during digit-2 slot count 2 -> outputs show reset values asynchronously, and after release the next active slot is digit 0.
